// File: rtl/nrzi_hdlc_rx.sv
// NRZI decoder and HDLC receiver: destuffing, flag/abort detection and byte
// assembly behind a 7-bit uncommitted-bit delay line.
module nrzi_hdlc_rx #(
  parameter int DLY = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       x,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       frame_end,
  output logic       frame_err,
  output logic       abort,
  output logic       in_frame
);
  localparam int unsigned ONES_W = 3;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              prev_x;
  logic [ONES_W-1:0] ones;
  logic [DLY-1:0]    dl_bit;
  logic [DLY-1:0]    dl_vld;
  logic [6:0]        sr;
  logic [CNT_W-1:0]  cnt;
  logic              got_byte;

  logic d, bit_one, bit_zero;
  logic ev_flag, ev_abort, ev_data0;
  logic push, commit, byte_done;
  logic y_valid_nxt, frame_end_nxt, frame_err_nxt, abort_nxt, in_frame_nxt;

  // Line-bit classification; a zero after five ones is stuffing and falls through
  assign d         = (x == prev_x);
  assign bit_one   = en & d;
  assign bit_zero  = en & ~d;
  assign ev_flag   = bit_zero & (ones == ONES_W'(6));
  assign ev_data0  = bit_zero & (ones <= ONES_W'(4));
  assign ev_abort  = bit_one & (ones == ONES_W'(6));
  assign push      = bit_one | ev_data0;
  assign commit    = push & dl_vld[DLY-1] & (state != HUNT);
  assign byte_done = commit & (cnt == CNT_W'(7));

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: if (ev_flag) state_nxt = SYNC;
      SYNC: begin
        if (ev_abort)    state_nxt = HUNT;
        else if (commit) state_nxt = DATA;
      end
      DATA: begin
        if (ev_abort)     state_nxt = HUNT;
        else if (ev_flag) state_nxt = SYNC;
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    y_valid_nxt   = byte_done;
    frame_end_nxt = 1'b0;
    frame_err_nxt = 1'b0;
    abort_nxt     = 1'b0;
    in_frame_nxt  = (state_nxt == DATA);
    if (state == DATA) begin
      frame_end_nxt = ev_flag & (cnt == CNT_W'(0)) & got_byte;
      frame_err_nxt = ev_flag & (cnt != CNT_W'(0));
      abort_nxt     = ev_abort;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid   <= 1'b0;
      frame_end <= 1'b0;
      frame_err <= 1'b0;
      abort     <= 1'b0;
      in_frame  <= 1'b0;
    end else begin
      y_valid   <= y_valid_nxt;
      frame_end <= frame_end_nxt;
      frame_err <= frame_err_nxt;
      abort     <= abort_nxt;
      in_frame  <= in_frame_nxt;
    end
  end

  // Delay line, ones counter and byte assembler; flag/abort override the assembler
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_x   <= 1'b1;
      ones     <= '0;
      dl_bit   <= '0;
      dl_vld   <= '0;
      sr       <= '0;
      cnt      <= '0;
      got_byte <= 1'b0;
      y        <= 8'h00;
    end else if (en) begin
      prev_x <= x;
      if (d) ones <= (ones == ONES_W'(7)) ? ones : ones + ONES_W'(1);
      else   ones <= '0;

      if (ev_flag || ev_abort) begin
        dl_vld <= '0;
      end else if (push) begin
        dl_bit <= {dl_bit[DLY-2:0], d};
        dl_vld <= {dl_vld[DLY-2:0], 1'b1};
      end

      if (commit) begin
        sr  <= {dl_bit[DLY-1], sr[6:1]};
        cnt <= cnt + CNT_W'(1);
        if (byte_done) begin
          y        <= {dl_bit[DLY-1], sr};
          got_byte <= 1'b1;
        end
      end
      if (ev_flag || ev_abort) begin
        cnt      <= '0;
        got_byte <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nrzi_hdlc_rx.sv
// Self-checking bench for nrzi_hdlc_rx: directed scenarios plus randomized
// frames compared against a frame-level HDLC reference model.
module tb_nrzi_hdlc_rx;
  localparam int END_EV = 256;
  localparam int ERR_EV = 257;
  localparam int ABT_EV = 258;

  logic       clk = 1'b0;
  logic       rst, en, x;
  logic [7:0] y;
  logic       y_valid, frame_end, frame_err, abort, in_frame;

  int errors = 0;
  int checks = 0;
  int obs[$];
  int obs_t[$];
  int inf_q[$];
  int exp_q[$];
  bit stream[$];
  int step_n;
  int srun;
  logic tx_prev;

  always #5 clk = ~clk;

  nrzi_hdlc_rx #(.DLY(7)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .y_valid(y_valid),
    .frame_end(frame_end), .frame_err(frame_err), .abort(abort), .in_frame(in_frame)
  );

  function automatic int qget(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  // One clock: drive at negedge, sample the result at the next negedge
  task automatic step(input logic r, input logic e, input logic xv);
    rst = r; en = e; x = xv;
    @(negedge clk);
    if (y_valid)   begin obs.push_back(int'(y)); obs_t.push_back(step_n); end
    if (frame_end) begin obs.push_back(END_EV);  obs_t.push_back(step_n); end
    if (frame_err) begin obs.push_back(ERR_EV);  obs_t.push_back(step_n); end
    if (abort)     begin obs.push_back(ABT_EV);  obs_t.push_back(step_n); end
    checks++;
    if (int'(frame_end) + int'(frame_err) + int'(abort) > 1) begin
      errors++;
      $display("FAIL exclusive_pulses step %0d: end=%b err=%b abort=%b, required at most one", step_n, frame_end, frame_err, abort);
    end
    if (!e && !r) begin
      checks++;
      if ({y_valid, frame_end, frame_err, abort} !== 4'b0) begin
        errors++;
        $display("FAIL idle_strobe_pulse step %0d: pulses=%b required 0000", step_n, {y_valid, frame_end, frame_err, abort});
      end
    end
    inf_q.push_back(int'(in_frame));
    step_n++;
  endtask

  task automatic send_bit(input bit d);
    logic xv;
    xv = d ? tx_prev : ~tx_prev;
    tx_prev = xv;
    step(1'b0, 1'b1, xv);
  endtask

  task automatic send_stream(input int gap_at, input bit rnd_gaps);
    logic t;
    foreach (stream[i]) begin
      if (i == gap_at) begin
        t = tx_prev;
        repeat (5) begin t = ~t; step(1'b0, 1'b0, t); end
      end
      if (rnd_gaps && $urandom_range(0, 7) == 0)
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'($urandom));
      send_bit(stream[i]);
    end
  endtask

  task automatic clear_obs();
    obs.delete(); obs_t.delete(); inf_q.delete(); step_n = 0;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    tx_prev = 1'b1;
    stream.delete();
    srun = 0;
    clear_obs();
  endtask

  task automatic add_flag();
    stream.push_back(0);
    repeat (6) stream.push_back(1);
    stream.push_back(0);
    srun = 0;
  endtask

  task automatic add_ones(input int n);
    repeat (n) stream.push_back(1);
  endtask

  // LSB-first payload bits with a zero inserted after every five ones
  task automatic add_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      stream.push_back(v[i]);
      if (v[i]) begin
        srun++;
        if (srun == 5) begin stream.push_back(0); srun = 0; end
      end else srun = 0;
    end
  endtask

  task automatic emit_bytes(input bit p[$], input int n);
    int v;
    for (int k = 0; k + 8 <= n; k += 8) begin
      v = 0;
      for (int j = 0; j < 8; j++) v |= int'(p[k+j]) << j;
      exp_q.push_back(v);
    end
  endtask

  // Frame-level model: everything between flags minus the 7 flag-prefix bits is payload
  task automatic ref_model();
    int run, n;
    bit synced;
    bit pend[$];
    run = 0; synced = 0; exp_q.delete();
    foreach (stream[i]) begin
      if (stream[i]) begin
        if (run == 6) begin
          if (synced && pend.size() > 7) begin
            pend.push_back(1);
            n = pend.size() - 7;
            emit_bytes(pend, n);
            exp_q.push_back(ABT_EV);
          end
          synced = 0; pend.delete();
        end else if (synced) pend.push_back(1);
        if (run < 7) run++;
      end else begin
        if (run == 6) begin
          if (synced) begin
            n = pend.size() - 7;
            if (n > 0) begin
              emit_bytes(pend, n);
              exp_q.push_back((n % 8 == 0) ? END_EV : ERR_EV);
            end
          end
          synced = 1; pend.delete();
        end else if (run <= 4 && synced) pend.push_back(0);
        run = 0;
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if ({y, y_valid, frame_end, frame_err, abort, in_frame} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0000", {y, y_valid, frame_end, frame_err, abort, in_frame});
    end
    tx_prev = 1'b1;
    clear_obs();
    repeat (4) step(1'b0, 1'b0, 1'($urandom));
    checks++;
    if (obs.size() != 0 || in_frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: events=%0d in_frame=%b required 0 and 0", obs.size(), in_frame);
    end
  endtask

  task automatic test_good_frame();
    do_reset();
    add_ones(8); add_flag(); add_bits(32'hA5, 8); add_flag(); add_ones(4);
    send_stream(-1, 0);
    checks++;
    if (obs.size() != 2) begin errors++; $display("FAIL good_count: got %0d events required 2", obs.size()); end
    checks++;
    if (qget(obs, 0) != 32'hA5 || qget(obs, 1) != END_EV) begin
      errors++; $display("FAIL good_events: got %0d,%0d required 165,%0d", qget(obs, 0), qget(obs, 1), END_EV);
    end
    checks++;
    if (qget(obs_t, 0) != 30 || qget(obs_t, 1) != 31) begin
      errors++; $display("FAIL good_timing: got steps %0d,%0d required 30,31", qget(obs_t, 0), qget(obs_t, 1));
    end
    checks++;
    if (qget(inf_q, 22) != 0 || qget(inf_q, 23) != 1 || qget(inf_q, 30) != 1 || qget(inf_q, 31) != 0) begin
      errors++;
      $display("FAIL good_in_frame: got %0d%0d%0d%0d required 0110", qget(inf_q, 22), qget(inf_q, 23), qget(inf_q, 30), qget(inf_q, 31));
    end
  endtask

  task automatic test_stuffing();
    do_reset();
    add_ones(3); add_flag(); add_bits(32'h3EFF, 16); add_flag(); add_ones(2);
    send_stream(-1, 0);
    checks++;
    if (obs.size() != 3 || qget(obs, 0) != 32'hFF || qget(obs, 1) != 32'h3E || qget(obs, 2) != END_EV) begin
      errors++;
      $display("FAIL stuffing: got n=%0d %0d,%0d,%0d required 255,62,%0d", obs.size(), qget(obs, 0), qget(obs, 1), qget(obs, 2), END_EV);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    add_ones(2); add_flag(); add_bits(32'hA5C, 12); add_flag(); add_ones(2);
    send_stream(-1, 0);
    checks++;
    if (obs.size() != 2 || qget(obs, 0) != 32'h5C || qget(obs, 1) != ERR_EV) begin
      errors++;
      $display("FAIL misaligned: got n=%0d %0d,%0d required 92,%0d", obs.size(), qget(obs, 0), qget(obs, 1), ERR_EV);
    end
  endtask

  task automatic test_abort();
    do_reset();
    add_ones(8); add_flag(); add_bits(32'h55, 8); add_ones(8); add_bits(32'h55, 8); add_ones(3);
    send_stream(-1, 0);
    checks++;
    if (obs.size() != 2 || qget(obs, 0) != 32'h55 || qget(obs, 1) != ABT_EV) begin
      errors++;
      $display("FAIL abort_events: got n=%0d %0d,%0d required 85,%0d", obs.size(), qget(obs, 0), qget(obs, 1), ABT_EV);
    end
    checks++;
    if (qget(obs_t, 1) != 30 || qget(inf_q, 29) != 1 || qget(inf_q, 30) != 0) begin
      errors++;
      $display("FAIL abort_timing: got step %0d in_frame %0d%0d required 30 10", qget(obs_t, 1), qget(inf_q, 29), qget(inf_q, 30));
    end
  endtask

  task automatic test_reset_mid();
    int hi;
    do_reset();
    add_ones(4); add_flag(); add_bits(32'h3CA5, 16); add_bits(32'h81, 3);
    send_stream(-1, 0);
    checks++;
    if (obs.size() != 1 || qget(obs, 0) != 32'hA5 || in_frame !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: got n=%0d y0=%0d in_frame=%b required 1,165,1", obs.size(), qget(obs, 0), in_frame);
    end
    step(1'b1, 1'b1, ~tx_prev);
    checks++;
    if ({y, y_valid, frame_end, frame_err, abort, in_frame} !== 13'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h required 0000", {y, y_valid, frame_end, frame_err, abort, in_frame});
    end
    tx_prev = 1'b1;
    clear_obs(); stream.delete(); srun = 0;
    add_bits(32'h10, 5); add_bits(32'h2211, 16); add_ones(2);
    send_stream(-1, 0);
    hi = 0;
    foreach (inf_q[i]) hi += inf_q[i];
    checks++;
    if (obs.size() != 0 || hi != 0) begin
      errors++; $display("FAIL midreset_after: got events=%0d in_frame_cycles=%0d required 0,0", obs.size(), hi);
    end
  endtask

  task automatic test_strobe();
    int a[$];
    int at[$];
    do_reset();
    add_ones(4); add_flag(); add_bits(32'h813C, 16); add_flag(); add_ones(2);
    send_stream(-1, 0);
    a = obs; at = obs_t;
    do_reset();
    add_ones(4); add_flag(); add_bits(32'h813C, 16); add_flag(); add_ones(2);
    send_stream(20, 0);
    checks++;
    if (obs.size() != 3 || qget(obs, 0) != 32'h3C || qget(obs, 1) != 32'h81 || qget(obs, 2) != END_EV) begin
      errors++;
      $display("FAIL strobe_events: got n=%0d %0d,%0d,%0d required 60,129,%0d", obs.size(), qget(obs, 0), qget(obs, 1), qget(obs, 2), END_EV);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (qget(obs, i) != qget(a, i) || qget(obs_t, i) != qget(at, i) + 5) begin
        errors++;
        $display("FAIL strobe_vs_nogap[%0d]: got %0d@%0d required %0d@%0d", i, qget(obs, i), qget(obs_t, i), qget(a, i), qget(at, i) + 5);
      end
    end
  endtask

  task automatic test_random();
    int kind, nb, n;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      add_ones($urandom_range(0, 10)); add_flag();
      for (int f = 0; f < 10; f++) begin
        kind = $urandom_range(0, 3);
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) add_bits(32'($urandom_range(0, 255)), 8);
        if (kind == 1) add_bits($urandom, $urandom_range(1, 7));
        if (kind == 2) begin
          add_ones($urandom_range(7, 9)); add_ones($urandom_range(0, 4)); add_flag();
        end else begin
          add_flag();
          if (kind == 3) begin add_ones(8); add_flag(); end
          if ($urandom_range(0, 2) == 0) add_flag();
        end
      end
      add_ones(2);
      ref_model();
      send_stream(-1, 1);
      n = (obs.size() > exp_q.size()) ? obs.size() : exp_q.size();
      checks++;
      if (obs.size() != exp_q.size()) begin
        errors++; $display("FAIL random_count round %0d: got %0d events required %0d", r, obs.size(), exp_q.size());
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (qget(obs, i) != qget(exp_q, i)) begin
          errors++; $display("FAIL random_event round %0d idx %0d: got %0d required %0d", r, i, qget(obs, i), qget(exp_q, i));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; x = 1'b1; tx_prev = 1'b1; step_n = 0; srun = 0;
    test_reset();
    test_good_frame();
    test_stuffing();
    test_misaligned();
    test_abort();
    test_reset_mid();
    test_strobe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nrzi_hdlc_rx.md
NRZI_HDLC_RX -- requirements
Module: nrzi_hdlc_rx

Interface
REQ-001 The module SHALL have parameter DLY, default 7, which is the depth of the uncommitted-bit delay line and is fixed at 7 for HDLC flag removal.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port en, input, 1 bit: line bit strobe; x is sampled only in cycles with en=1.
REQ-005 The module SHALL have port x, input, 1 bit: NRZI-encoded serial line bit.
REQ-006 The module SHALL have port y, output, 8 bits: received data byte, LSB first on the line, valid when y_valid=1.
REQ-007 The module SHALL have port y_valid, output, 1 bit: one-cycle pulse when y holds a new byte.
REQ-008 The module SHALL have port frame_end, output, 1 bit: one-cycle pulse on a closing flag of a good frame.
REQ-009 The module SHALL have port frame_err, output, 1 bit: one-cycle pulse on a closing flag after a non-byte-aligned frame.
REQ-010 The module SHALL have port abort, output, 1 bit: one-cycle pulse on an abort sequence inside a frame.
REQ-011 The module SHALL have port in_frame, output, 1 bit: level, high while the FSM is in DATA.

Function
REQ-012 NRZI decoding SHALL give decoded d=1 when x equals the previous sampled x and d=0 when it differs; the previous-x register SHALL be updated only on en=1.
REQ-013 A saturating counter ones (0..7) SHALL count consecutive decoded 1s: d=1 increments it, and d=0 clears it after classification.
REQ-014 Classification of d=0 SHALL be: ones==5 means a stuffed zero, dropped entirely and not entered into the delay line; ones==6 means a flag; ones<=4 means a data bit.
REQ-015 The cycle in which ones reaches 7 SHALL be an abort event; further 1s SHALL raise no further abort events until a 0 is seen.
REQ-016 Every data bit and every decoded 1 SHALL be pushed into a DLY-deep delay line with per-entry valid flags; a push onto a full line SHALL commit the oldest bit to the byte assembler.
REQ-017 The byte assembler SHALL shift committed bits in LSB first with a 3-bit count; on the 8th bit, y SHALL be loaded and y_valid pulsed in the next cycle, and the count SHALL wrap to 0.
REQ-018 A flag SHALL invalidate all delay-line entries (the 0111111 of the flag is never committed), and abort SHALL do the same.
REQ-019 The FSM SHALL have states HUNT, SYNC, and DATA.
REQ-020 In HUNT, all bits SHALL be discarded (no commits), and a flag SHALL move the FSM to SYNC.
REQ-021 In SYNC, a flag SHALL keep the FSM in SYNC (back-to-back or shared flags), the first commit SHALL move it to DATA, and abort SHALL move it to HUNT without an abort pulse.
REQ-022 In DATA, a flag with byte count==0 and at least one byte received SHALL pulse frame_end and move the FSM to SYNC.
REQ-023 In DATA, a flag with byte count!=0 SHALL pulse frame_err, discard the partial byte, and move the FSM to SYNC.
REQ-024 In DATA, abort SHALL pulse abort, discard the partial byte, and move the FSM to HUNT.
REQ-025 All outputs SHALL be registered, and pulses SHALL appear in the cycle after the en cycle that causes them.
REQ-026 At most one of frame_end, frame_err, and abort SHALL be asserted in any cycle; y_valid and frame_end SHALL never coincide, because a flag commits nothing.
REQ-027 With en=0, all state SHALL hold and all pulse outputs SHALL be 0.
REQ-028 Stuffed-zero removal SHALL apply in every state; in HUNT it only affects ones counting.

Reset
REQ-029 While rst=1 at a rising edge, the FSM SHALL go to HUNT, ones to 0, previous-x to 1 (idle line), delay-line valid flags and byte count to 0, y to 8'h00, and y_valid, frame_end, frame_err, abort, and in_frame to 0.
REQ-030 rst SHALL take priority over en, and rst mid-frame SHALL drop the partial frame silently with no pulses.

Verification
REQ-031 Scenario good frame: decoded stream flag 0x7E, byte 0xA5, flag 0x7E, NRZI-encoded from idle 1 -> exactly one y_valid with y=8'hA5, then one frame_end, and in_frame high between them.
REQ-032 Scenario stuffing: payload 0xFF 0x3E with HDLC bit stuffing between flags -> y=8'hFF, then y=8'h3E, then frame_end, with no stuffed bit visible and no frame_err.
REQ-033 Scenario misaligned: flag, 12 data bits, flag -> one y_valid, then frame_err, and no frame_end.
REQ-034 Scenario abort: flag, 0x55, then eight decoded 1s -> y=8'h55, then one abort pulse, with in_frame low and the FSM in HUNT; a following 0x55 without a flag produces no y_valid.
REQ-035 Scenario reset and strobe: rst asserted mid-byte -> all outputs 0 next cycle; en low for 5 cycles mid-frame with x toggling -> identical output to the same stream without the gap.
